mic_sample_buffer: RTL and testbench
====================================

# mic_sample_buffer

SPI capture engine and sample FIFO for the microphone ADC path. On each sample request from the interval timer, it runs one 16-bit SPI read frame and pushes the word into an internal FIFO. The APB wrapper drains that FIFO with single-cycle pop strobes. The block sits between the timer/APB wrapper and the external microphone ADC, so CPU reads are decoupled from the sample clock.

## Interface
- DEPTH, 16, FIFO entries; power of two, at least 2
- SCLK_DIV, 4, PCLK cycles per sclk half-period; at least 1
- THRESH, 8, fill level that raises irq; range 1..DEPTH
- PCLK  in  1  sole clock; all logic on its rising edge
- PRESETn  in  1  asynchronous, active-low reset
- enable  in  1  capture enable; when 0, sample_req is ignored
- sample_req  in  1  one-cycle pulse requesting one sample frame
- MISO  in  1  serial data from the ADC, MSB first
- CS_b  out  1  ADC chip select, active low; reset 1
- sclk  out  1  serial clock, idles high; reset 1
- pop  in  1  one-cycle strobe that removes the head entry
- rd_data  out  16  head entry (show-ahead); 16'h0000 when empty
- count  out  $clog2(DEPTH)+1  current occupancy; reset 0
- empty  out  1  count==0; reset 1
- full  out  1  count==DEPTH; reset 0
- overflow  out  1  sticky flag: a sample was dropped; reset 0
- clr_ovf  in  1  one-cycle strobe that clears overflow
- irq  out  1  registered; high when count>=THRESH or overflow; reset 0

## Operation
- FSM states: IDLE, SHIFT, QUIET. Reset state is IDLE.
- **IDLE:**
  - Start condition: sample_req&enable, or the pending flag is set.
  - On start: enter SHIFT, drive CS_b=0, clear the bit counter and the pending flag.
- **SHIFT:** 16 bit periods, each 2*SCLK_DIV cycles.
  - sclk is low for the first SCLK_DIV cycles of each period and high for the rest.
  - MISO is shifted into a 16-bit register, MSB first, on the PCLK edge that drives sclk 0→1.
  - On the edge that ends bit 15: CS_b←1, sclk←1, the word is pushed to the FIFO, and the FSM enters QUIET.
- **QUIET:** CS_b stays high for 2*SCLK_DIV cycles, then the FSM returns to IDLE.
- **Pending request:** sample_req&enable while in SHIFT or QUIET sets a one-deep pending flag.
  - Further requests while the flag is already set are discarded.
  - enable=0 clears the flag. A frame already in progress always completes.
- **Push while full:** the word is dropped and overflow←1.
  - If pop is asserted on the same edge, the pop is taken and the push is accepted; count stays DEPTH and no overflow is raised.
- **Pop while empty:** ignored; count stays 0.
- **Simultaneous push and pop** (not full, not empty): count is unchanged and both pointers advance.
- **overflow:** cleared by clr_ovf. If a dropped push and clr_ovf occur on the same edge, the set wins.
- **Pointers:** read and write pointers wrap modulo DEPTH. count is computed with a width of $clog2(DEPTH)+1 bits.
- **Reset** (asynchronous, at any time, including mid-frame): FSM→IDLE, CS_b=1, sclk=1, FIFO emptied, pending=0, overflow=0, irq=0, shift register=0.

## Timing
- CS_b falls on the PCLK edge that samples the start condition, call it E0.
- Data sampling edges: bit k (k=0..15, MSB first) is sampled at edge E0 + 2*SCLK_DIV*k + SCLK_DIV.
- Push edge: E0 + 32*SCLK_DIV (128 for the default SCLK_DIV). CS_b rises on this edge, and count/empty/full/rd_data reflect the new word immediately after it.
- Earliest next frame: CS_b falls at E0 + 34*SCLK_DIV (136 for the default), whether the start comes from the pending flag or a fresh request.
- pop: count decrements and rd_data shows the next entry immediately after the edge on which pop is sampled. There is no read latency on rd_data.
- irq is registered and lags count/overflow changes by exactly one cycle.

## Test plan
- **Single frame:** reset, enable=1, MISO model returns 16'hA5C3, one sample_req.
  - CS_b low for exactly 128 cycles.
  - sclk shows 16 pulses, each low 4 / high 4.
  - After the push: count=1, rd_data=16'hA5C3.
  - pop → empty=1, rd_data=16'h0000.
- **Back-to-back requests:** three sample_req pulses 10 cycles apart.
  - Exactly two frames run: the first request plus one pending.
  - The second CS_b fall is 136 cycles after the first.
  - Final count=2.
- **Fill and overflow:** 17 frames with words 0..16 and no pops.
  - full=1 after the 16th frame; the 17th word is dropped and overflow=1.
  - irq goes high one cycle after count reaches 8.
  - Popping all entries returns 0..15 in order.
  - clr_ovf clears overflow, and irq drops once count<8.
- **Full with pop on the push edge:** with count=16, assert pop on the push edge.
  - count stays 16, overflow stays 0.
  - The last entry read out equals the new word.
- **Reset mid-frame:** assert PRESETn=0 during bit 7.
  - CS_b=1, sclk=1, count=0 immediately.
  - After release, a new request produces a clean 128-cycle frame.
- **enable gating:** enable=0 with sample_req pulses → no CS_b activity. Drop enable during QUIET with a request pending → no second frame.

Source files
------------

// File: rtl/mic_sample_buffer_if.sv
// Signal bundle between the microphone capture/FIFO block and its timer,
// APB wrapper and external ADC.
interface mic_sample_buffer_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          enable;
  logic          sample_req;
  logic          MISO;
  logic          CS_b;
  logic          sclk;
  logic          pop;
  logic [15:0]   rd_data;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          clr_ovf;
  logic          irq;

  modport master (
    output enable, sample_req, MISO, pop, clr_ovf,
    input  CS_b, sclk, rd_data, count, empty, full, overflow, irq
  );

  modport slave (
    input  enable, sample_req, MISO, pop, clr_ovf,
    output CS_b, sclk, rd_data, count, empty, full, overflow, irq
  );
endinterface

// File: rtl/mic_sample_buffer.sv
// SPI read-frame engine for the microphone ADC feeding a show-ahead sample FIFO
// that the APB wrapper drains with pop strobes.
module mic_sample_buffer #(
  parameter int DEPTH    = 16,
  parameter int SCLK_DIV = 4,
  parameter int THRESH   = 8
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  mic_sample_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(2 * SCLK_DIV) + 1;
  localparam logic [DW-1:0] DIV_HALF  = DW'(SCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_END   = DW'(2 * SCLK_DIV - 1);
  localparam logic [DW-1:0] QUIET_END = DW'(2 * SCLK_DIV - 2);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH_C  = CW'(THRESH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    QUIET = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   sr_q, sr_d;
  logic          cs_b_q, cs_b_d;
  logic          sclk_q, sclk_d;
  logic          pend_q, pend_d;
  logic          req_s, push_s;

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, irq_q, irq_d;
  logic          empty_s, full_s, pop_ok_s, push_ok_s;

  // Frame sequencer: div_q counts PCLKs inside one sclk period (or the quiet gap).
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    cs_b_d  = cs_b_q;
    sclk_d  = sclk_q;
    pend_d  = pend_q;
    push_s  = 1'b0;
    req_s   = bus.sample_req & bus.enable;
    case (state_q)
      IDLE: begin
        if (req_s | (pend_q & bus.enable)) begin
          state_d = SHIFT;
          cs_b_d  = 1'b0;
          sclk_d  = 1'b0;
          div_d   = '0;
          bit_d   = 4'd0;
          pend_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        div_d  = div_q + DW'(1);
        pend_d = pend_q | req_s;
        if (div_q == DIV_HALF) begin
          sclk_d = 1'b1;
          sr_d   = {sr_q[14:0], bus.MISO};
        end else if (div_q == DIV_END) begin
          div_d = '0;
          if (bit_q == 4'd15) begin
            cs_b_d  = 1'b1;
            sclk_d  = 1'b1;
            push_s  = 1'b1;
            state_d = QUIET;
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
          end
        end else begin
          sclk_d = sclk_q;
        end
      end
      QUIET: begin
        div_d  = div_q + DW'(1);
        pend_d = pend_q | req_s;
        // Leave one edge early so IDLE can start the next frame exactly 2*SCLK_DIV after push.
        if (div_q == QUIET_END) begin
          state_d = IDLE;
          div_d   = '0;
        end else begin
          state_d = QUIET;
        end
      end
      default: begin
        state_d = IDLE;
        cs_b_d  = 1'b1;
        sclk_d  = 1'b1;
        div_d   = '0;
      end
    endcase
    pend_d = pend_d & bus.enable;
  end

  // FIFO bookkeeping: a pop on a full FIFO frees the slot for a same-edge push.
  always_comb begin
    empty_s   = (count_q == '0);
    full_s    = (count_q == DEPTH_C);
    pop_ok_s  = bus.pop & ~empty_s;
    push_ok_s = push_s & (~full_s | pop_ok_s);
    wr_d      = push_ok_s ? wr_q + AW'(1) : wr_q;
    rd_d      = pop_ok_s ? rd_q + AW'(1) : rd_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = (push_s & ~push_ok_s) | (ovf_q & ~bus.clr_ovf);
    irq_d = (count_q >= THRESH_C) | ovf_q;
  end

  // State, SPI pins and FIFO control registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= 4'd0;
      sr_q    <= 16'h0000;
      cs_b_q  <= 1'b1;
      sclk_q  <= 1'b1;
      pend_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      cs_b_q  <= cs_b_d;
      sclk_q  <= sclk_d;
      pend_q  <= pend_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_d;
    end
  end

  // Sample storage.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (push_ok_s) begin
      mem_q[wr_q] <= sr_q;
    end else begin
      mem_q[wr_q] <= mem_q[wr_q];
    end
  end

  assign bus.CS_b     = cs_b_q;
  assign bus.sclk     = sclk_q;
  assign bus.rd_data  = empty_s ? 16'h0000 : mem_q[rd_q];
  assign bus.count    = count_q;
  assign bus.empty    = empty_s;
  assign bus.full     = full_s;
  assign bus.overflow = ovf_q;
  assign bus.irq      = irq_q;
endmodule

// File: tb/tb_mic_sample_buffer.sv
// Bench for mic_sample_buffer: ADC stand-in on the SPI pins, queue-based
// reference model of the FIFO/overflow/irq behaviour.
module tb_mic_sample_buffer;
  localparam int DEPTH  = 16;
  localparam int DIV    = 4;
  localparam int THRESH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mic_sample_buffer_if #(.DEPTH(DEPTH)) bus ();

  mic_sample_buffer #(.DEPTH(DEPTH), .SCLK_DIV(DIV), .THRESH(THRESH)) dut (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] model_q [$];
  bit          ovf_m = 1'b0;

  // ADC stand-in: loads a word on CS_b fall, moves to the next bit after each sclk rise.
  logic [15:0] adc_word  = 16'h0000;
  logic [15:0] cur_word  = 16'h0000;
  logic        miso_r    = 1'b0;
  logic        prev_cs   = 1'b1;
  logic        prev_sclk = 1'b1;
  int          bit_i     = 0;
  assign bus.MISO = miso_r;
  always @(bus.CS_b, bus.sclk) begin
    if (prev_cs === 1'b1 && bus.CS_b === 1'b0) begin
      cur_word = adc_word;
      bit_i    = 15;
      miso_r   = cur_word[15];
    end else if (prev_sclk === 1'b0 && bus.sclk === 1'b1 && bus.CS_b === 1'b0 && bit_i > 0) begin
      bit_i  = bit_i - 1;
      miso_r = cur_word[bit_i];
    end
    prev_cs   = bus.CS_b;
    prev_sclk = bus.sclk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit irq_m();
    return (model_q.size() >= THRESH) || ovf_m;
  endfunction

  function automatic void model_push(input logic [15:0] w, input bit with_pop);
    bit was_full;
    was_full = (model_q.size() == DEPTH);
    if (with_pop && model_q.size() > 0) void'(model_q.pop_front());
    if (!was_full || with_pop) model_q.push_back(w);
    else ovf_m = 1'b1;
  endfunction

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, 32'(bus.count), model_q.size());
    chk({tag, "_empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    chk({tag, "_full"}, 32'(bus.full), 32'(model_q.size() == DEPTH));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(ovf_m));
    chk({tag, "_rd"}, 32'(bus.rd_data), 32'((model_q.size() > 0) ? model_q[0] : 16'h0000));
  endtask

  // One request, one frame; checks frame shape, push result and irq lag.
  task automatic do_frame(input logic [15:0] w, input bit pop_at_push);
    int   n, sbad, pulses;
    logic prev_s;
    bit   old_irq;
    adc_word = w;
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    chk("cs_fall", 32'(bus.CS_b), 32'd0);
    n = 0; sbad = 0; pulses = 0; prev_s = 1'b1;
    while (bus.CS_b === 1'b0 && n < 1000) begin
      if (bus.sclk !== (((n % (2 * DIV)) >= DIV) ? 1'b1 : 1'b0)) sbad++;
      if (prev_s === 1'b0 && bus.sclk === 1'b1) pulses++;
      prev_s = bus.sclk;
      if (pop_at_push && n == 32 * DIV - 1) begin
        chk("pp_head", 32'(bus.rd_data), 32'(model_q[0]));
        bus.pop = 1'b1;
      end
      n++;
      tick();
      bus.pop = 1'b0;
    end
    chk("cs_low_cycles", n, 32 * DIV);
    chk("sclk_shape", sbad, 0);
    chk("sclk_pulses", pulses, 16);
    old_irq = irq_m();
    model_push(w, pop_at_push);
    chk_state("frame");
    chk("frame_irq_lag", 32'(bus.irq), 32'(old_irq));
    repeat (2 * DIV) tick();
    chk("frame_irq", 32'(bus.irq), 32'(irq_m()));
  endtask

  task automatic do_pop(input string tag);
    bit old_irq;
    old_irq = irq_m();
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    chk_state(tag);
    chk({tag, "_irq_lag"}, 32'(bus.irq), 32'(old_irq));
    tick();
    chk({tag, "_irq"}, 32'(bus.irq), 32'(irq_m()));
  endtask

  task automatic do_clr();
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    ovf_m = 1'b0;
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    tick();
    chk("clr_irq", 32'(bus.irq), 32'(irq_m()));
  endtask

  // Free-running request pattern; counts CS_b falls and models each completed frame.
  task automatic watch(input int ncyc, input int gap, input int nreq, input int en_off,
                       output int falls, output int t_first, output int t_second);
    logic pcs;
    falls = 0; t_first = -1; t_second = -1;
    pcs = bus.CS_b;
    for (int t = 0; t < ncyc; t++) begin
      bus.sample_req = ((t % gap) == 0) && ((t / gap) < nreq);
      bus.enable     = (t < en_off);
      tick();
      if (pcs === 1'b1 && bus.CS_b === 1'b0) begin
        falls++;
        if (falls == 1) t_first = t;
        else if (falls == 2) t_second = t;
      end
      if (pcs === 1'b0 && bus.CS_b === 1'b1) model_push(adc_word, 1'b0);
      pcs = bus.CS_b;
    end
    bus.sample_req = 1'b0;
    bus.enable     = 1'b1;
  endtask

  initial begin
    int          f, ta, tb2;
    logic [15:0] w;
    bus.enable = 1'b0; bus.sample_req = 1'b0; bus.pop = 1'b0; bus.clr_ovf = 1'b0;

    // Reset values
    repeat (3) tick();
    chk("rst_cs", 32'(bus.CS_b), 32'd1);
    chk("rst_sclk", 32'(bus.sclk), 32'd1);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk_state("rst");
    @(negedge clk); rst_n = 1'b1;
    tick();
    bus.enable = 1'b1;

    // Single frame and pop, then pop on empty
    do_frame(16'hA5C3, 1'b0);
    chk("single_count", 32'(bus.count), 32'd1);
    chk("single_data", 32'(bus.rd_data), 32'h0000A5C3);
    do_pop("single_pop");
    chk("single_empty", 32'(bus.empty), 32'd1);
    chk("single_rd0", 32'(bus.rd_data), 32'd0);
    do_pop("empty_pop");

    // Back-to-back requests: first plus one pending
    adc_word = 16'h3C5A;
    watch(400, 10, 3, 1000, f, ta, tb2);
    chk("b2b_frames", f, 2);
    chk("b2b_spacing", tb2 - ta, 34 * DIV);
    chk("b2b_count", 32'(bus.count), 32'd2);
    chk_state("b2b");
    do_pop("b2b_pop0");
    do_pop("b2b_pop1");

    // Fill to overflow with words 0..16, clear, drain in order
    for (int i = 0; i <= DEPTH; i++) do_frame(16'(i), 1'b0);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_ovf", 32'(bus.overflow), 32'd1);
    do_clr();
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_order", 32'(bus.rd_data), i);
      do_pop("fill_pop");
    end

    // Full FIFO with pop on the push edge
    for (int i = 0; i < DEPTH; i++) do_frame(16'($urandom()), 1'b0);
    w = 16'($urandom());
    do_frame(w, 1'b1);
    chk("pp_count", 32'(bus.count), DEPTH);
    chk("pp_ovf", 32'(bus.overflow), 32'd0);
    repeat (DEPTH - 1) do_pop("pp_drain");
    chk("pp_last", 32'(bus.rd_data), 32'(w));
    do_pop("pp_final");

    // Reset during bit 7 of a frame
    do_frame(16'h1234, 1'b0);
    adc_word = 16'($urandom());
    bus.sample_req = 1'b1;
    tick();
    bus.sample_req = 1'b0;
    repeat (15 * DIV) tick();
    rst_n = 1'b0;
    #1;
    model_q.delete();
    ovf_m = 1'b0;
    chk("mid_rst_cs", 32'(bus.CS_b), 32'd1);
    chk("mid_rst_sclk", 32'(bus.sclk), 32'd1);
    chk("mid_rst_irq", 32'(bus.irq), 32'd0);
    chk_state("mid_rst");
    tick();
    @(negedge clk); rst_n = 1'b1;
    tick();
    do_frame(16'($urandom()), 1'b0);
    do_pop("mid_rst_pop");

    // enable gating
    adc_word = 16'hBEEF;
    watch(100, 10, 3, 0, f, ta, tb2);
    chk("en_off_frames", f, 0);
    watch(300, 10, 2, 30 * DIV + 10, f, ta, tb2);
    chk("en_drop_frames", f, 1);
    repeat (200) tick();
    chk("en_drop_idle", 32'(bus.CS_b), 32'd1);
    chk_state("en_drop");
    do_pop("en_pop");

    // Randomized mix of frames, pops and overflow clears
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    do_frame(16'($urandom()), (model_q.size() > 0) && ($urandom_range(0, 3) == 0));
        2:       do_pop("rnd_pop");
        default: do_clr();
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
